// File: rtl/mag_cook_ctrl_pkg.sv
// Shared definitions for the magnetron cook controller.
// State encodings are visible on the state output.
package mag_cook_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } mag_state_t;

    localparam logic [1:0] MAG_IDLE  = 2'd0;
    localparam logic [1:0] MAG_COOK  = 2'd1;
    localparam logic [1:0] MAG_PAUSE = 2'd2;
    localparam logic [1:0] MAG_DONE  = 2'd3;

endpackage

// File: rtl/mag_cook_ctrl_tick.sv
// One-second prescaler for the cook timer.
// Counts only while enabled; holds its phase otherwise.
module mag_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler: load restarts the second, en advances it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CMAX) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en & (cnt == CMAX);

endmodule

// File: rtl/mag_cook_ctrl.sv
// Magnetron cook controller: countdown timer,
// slot-based power duty cycle, pause/resume and door interlock.
module mag_cook_ctrl
    import mag_cook_ctrl_pkg::*;
#(
    parameter int TIME_W     = 8,
    parameter int TICK_DIV   = 1000,
    parameter int PWR_LEVELS = 4,
    parameter int PWR_W      = $clog2(PWR_LEVELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  power_in,
    output logic              mag_on,
    output logic [TIME_W-1:0] remaining,
    output logic [1:0]        state,
    output logic              done
);

    localparam logic [PWR_W-1:0] SLOT_MAX = PWR_W'(PWR_LEVELS - 1);

    mag_state_t       cur;
    mag_state_t       nxt;
    logic [PWR_W-1:0] pwr;
    logic [PWR_W-1:0] slot;
    logic             start_ok;
    logic             run;
    logic             load;
    logic             clr;
    logic             tick;

    assign start_ok = ~startn & door_closed & (time_in != '0);

    mag_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .load (load),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= ST_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next state; in COOK clear beats door/stop, which beat the tick.
    always_comb begin
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (start_ok) nxt = ST_COOK;
            end
            ST_COOK: begin
                if (!clearn) begin
                    nxt = ST_IDLE;
                end else if (!door_closed || !stopn) begin
                    nxt = ST_PAUSE;
                end else if (tick && remaining == TIME_W'(1)) begin
                    nxt = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (!clearn) begin
                    nxt = ST_IDLE;
                end else if (!startn && stopn && door_closed) begin
                    nxt = ST_COOK;
                end
            end
            ST_DONE: begin
                if (!clearn || !door_closed || !startn) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs and datapath controls; door gates mag_on without latency.
    always_comb begin
        run    = (cur == ST_COOK) & clearn & door_closed & stopn;
        load   = (cur == ST_IDLE) & start_ok;
        clr    = ((cur == ST_COOK) | (cur == ST_PAUSE)) & ~clearn;
        done   = (cur == ST_DONE);
        mag_on = (cur == ST_COOK) & door_closed & (slot <= pwr);
    end

    // Remaining seconds, power setting and duty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            pwr       <= '0;
            slot      <= '0;
        end else if (load) begin
            remaining <= time_in;
            pwr       <= power_in;
            slot      <= '0;
        end else if (clr) begin
            remaining <= '0;
        end else if (tick) begin
            if (remaining <= TIME_W'(1)) begin
                remaining <= '0;
            end else begin
                remaining <= remaining - 1'b1;
            end
            slot <= (slot == SLOT_MAX) ? '0 : slot + 1'b1;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mag_cook_ctrl.sv
// Randomised bench for mag_cook_ctrl against a cooked-time model,
// plus directed cook, pause, clear and reset scenarios.
module tb_mag_cook_ctrl;

    localparam int TD = 4;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       clearn = 1'b1;
    logic       door_closed = 1'b1;
    logic [7:0] time_in = 8'd0;
    logic [1:0] power_in = 2'd0;
    logic       mag_on;
    logic [7:0] remaining;
    logic [1:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: state, loaded time, cycles actually cooked, power.
    int m_st = 0;
    int m_time = 0;
    int m_cooked = 0;
    int m_pwr = 0;

    mag_cook_ctrl #(
        .TIME_W     (8),
        .TICK_DIV   (TD),
        .PWR_LEVELS (PL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .time_in     (time_in),
        .power_in    (power_in),
        .mag_on      (mag_on),
        .remaining   (remaining),
        .state       (state),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int exp_rem();
        return m_time - m_cooked / TD;
    endfunction

    function automatic int exp_mag();
        int sl;
        sl = (m_cooked / TD) % PL;
        return (m_st == 1 && door_closed && sl <= m_pwr) ? 1 : 0;
    endfunction

    // Reference: elapsed cook time decides remaining, slot and DONE.
    always @(posedge clk or posedge rst) begin
        int nc;
        if (rst) begin
            m_st <= 0;
            m_time <= 0;
            m_cooked <= 0;
            m_pwr <= 0;
        end else begin
            case (m_st)
                0: if (!startn && door_closed && time_in != 0) begin
                    m_st <= 1;
                    m_time <= int'(time_in);
                    m_pwr <= int'(power_in);
                    m_cooked <= 0;
                end
                1: if (!clearn) begin
                    m_st <= 0;
                    m_time <= 0;
                    m_cooked <= 0;
                end else if (!door_closed || !stopn) begin
                    m_st <= 2;
                end else begin
                    nc = m_cooked + 1;
                    m_cooked <= nc;
                    if (nc == m_time * TD) m_st <= 3;
                end
                2: if (!clearn) begin
                    m_st <= 0;
                    m_time <= 0;
                    m_cooked <= 0;
                end else if (!startn && stopn && door_closed) begin
                    m_st <= 1;
                end
                default: if (!clearn || !door_closed || !startn) begin
                    m_st <= 0;
                end
            endcase
        end
    end

    // Compare every cycle, well after inputs settle.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            lit("state", int'(state), m_st);
            lit("remaining", int'(remaining), exp_rem());
            lit("mag_on", int'(mag_on), exp_mag());
            lit("done", int'(done), (m_st == 3) ? 1 : 0);
        end
    end

    task automatic start(input int t, input int p);
        @(negedge clk);
        time_in = 8'(t);
        power_in = 2'(p);
        startn = 1'b0;
    endtask

    task automatic run_count(output int on_cnt, output int cyc);
        bit fin;
        on_cnt = 0;
        cyc = 0;
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            startn = 1'b1;
            #3;
            if (done) begin
                fin = 1'b1;
            end else begin
                if (mag_on) on_cnt++;
                cyc++;
            end
        end
        if (!fin) lit("done_timeout", 0, 1);
    endtask

    int on_c;
    int cy;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #3;
        lit("rst_state", int'(state), 0);
        lit("rst_mag", int'(mag_on), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full power, 3 s: 12 cycles on, then DONE.
        start(3, 3);
        run_count(on_c, cy);
        lit("s1_on", on_c, 12);
        lit("s1_cyc", cy, 12);
        lit("s1_state", int'(state), 3);
        lit("s1_rem", int'(remaining), 0);

        @(negedge clk);
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;

        // Power 1 of 4, 4 s: half duty.
        start(4, 1);
        run_count(on_c, cy);
        lit("s2_on", on_c, 8);
        lit("s2_cyc", cy, 16);

        @(negedge clk);
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;

        // Door opens mid-second, then resume.
        start(3, 3);
        repeat (6) begin
            @(negedge clk);
            startn = 1'b1;
        end
        @(negedge clk);
        door_closed = 1'b0;
        #3;
        lit("s3_mag_drop", int'(mag_on), 0);
        @(negedge clk);
        #3;
        lit("s3_pause", int'(state), 2);
        lit("s3_rem", int'(remaining), 2);
        @(negedge clk);
        #3;
        lit("s3_hold", int'(remaining), 2);
        @(negedge clk);
        door_closed = 1'b1;
        startn = 1'b0;
        run_count(on_c, cy);
        lit("s3_resume", cy, 6);

        // Clear from DONE, then zero-time start ignored.
        @(negedge clk);
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;
        #3;
        lit("s5_idle", int'(state), 0);
        lit("s5_done", int'(done), 0);
        time_in = 8'd0;
        startn = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        lit("s4_zero", int'(state), 0);

        // Stop and start together hold PAUSE; clear in COOK.
        start(5, 2);
        @(negedge clk);
        startn = 1'b1;
        @(negedge clk);
        stopn = 1'b0;
        startn = 1'b0;
        @(negedge clk);
        #3;
        lit("s4_pause", int'(state), 2);
        @(negedge clk);
        #3;
        lit("s4_stay", int'(state), 2);
        stopn = 1'b1;
        @(negedge clk);
        startn = 1'b1;
        #3;
        lit("s5_cook", int'(state), 1);
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;
        #3;
        lit("s5_clr", int'(state), 0);
        lit("s5_rem", int'(remaining), 0);

        // Shortest cook, then DONE flag.
        start(1, 0);
        run_count(on_c, cy);
        lit("s5_short", cy, 4);
        lit("s5_flag", int'(done), 1);
        @(negedge clk);
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;

        // Async reset in the middle of a cycle.
        start(9, 3);
        repeat (5) begin
            @(negedge clk);
            startn = 1'b1;
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        lit("s6_mag", int'(mag_on), 0);
        lit("s6_state", int'(state), 0);
        lit("s6_rem", int'(remaining), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random panel activity.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            startn = ($urandom_range(0, 5) != 0);
            stopn = ($urandom_range(0, 19) != 0);
            clearn = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 24) == 0) door_closed = ~door_closed;
            time_in = 8'($urandom_range(0, 6));
            power_in = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #4;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
